yarvi_mq: RTL and testbench
===========================

Name: yarvi_mq

Overview:
- Memory request queue between yarvi_ex and yarvi_me.
- Buffers ex memory requests (loads/stores) in a FIFO and presents them in order to me under the me_ready handshake.
- Tracks outstanding loads against me_readdatavalid so ex can stall on full and fences can wait for idle.
- Widths use the shared `VMSB/`XMSB macros from yarvi.h.

Parameters:
- DEPTH_LG2, 2, log2 of FIFO entries (4 entries default; legal 1..4).
- MAX_LOADS, 3, maximum loads issued to me and not yet returned; legal 1..15.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  ex request valid.
- writeenable  in  1  1=store, 0=load.
- address  in  `VMSB+1  byte address.
- writedata  in  `XMSB+1  store data.
- sizelg2  in  2  access size log2 (0=B, 1=H, 2=W, 3=D).
- readtag  in  5  destination register tag for a load.
- readsignextend  in  1  load sign-extend flag.
- mq_full  out  1  queue cannot accept this cycle; ex must hold.
- mq_idle  out  1  FIFO empty and no loads outstanding.
- mq_valid  out  1  head request valid toward me.
- mq_writeenable  out  1  head field.
- mq_address  out  `VMSB+1  head field.
- mq_writedata  out  `XMSB+1  head field.
- mq_sizelg2  out  2  head field.
- mq_readtag  out  5  head field.
- mq_readsignextend  out  1  head field.
- me_ready  in  1  me accepts head this cycle.
- me_readdatavalid  in  1  one load result returned this cycle.
- mq_error  out  1  sticky: overflow (enqueue while full) or underflow (readdatavalid with zero loads outstanding).

Behaviour:
- Reset (async assert, sync release):
  - rd/wr pointers, count, load counter and mq_error are all 0.
  - mq_valid=0, mq_full=0, mq_idle=1.
  - Payload outputs are 0.
- State:
  - Circular buffer of 2^DEPTH_LG2 entries.
  - Pointers are DEPTH_LG2 bits and wrap naturally.
  - count is DEPTH_LG2+1 bits.
- mq_full = (count == 2^DEPTH_LG2). It is registered-state derived only and never depends on me_ready in the same cycle.
- Enqueue when valid && !mq_full. Entry is written at wr_ptr; wr_ptr++.
- valid && mq_full:
  - Request dropped, mq_error set (sticky until reset).
  - State otherwise unchanged.
- Latency: request enqueued in cycle N is visible on mq_* in cycle N+1 at the earliest (no combinational bypass).
- Head and issue:
  - mq_* payload is the entry at rd_ptr.
  - mq_valid = (count != 0) && !(head is load && loads == MAX_LOADS).
- Dequeue when mq_valid && me_ready; rd_ptr++.
- Payload stability: while mq_valid=1 and me_ready=0, the payload is held stable.
- Simultaneous enqueue + dequeue: count unchanged, both pointers advance. Enqueue is still refused if full at cycle start.
- Load counter `loads`, width 4:
  - +1 on dequeue of a load (writeenable=0).
  - -1 on me_readdatavalid.
  - Both in the same cycle: unchanged.
- me_readdatavalid with loads==0 and no same-cycle load dequeue: mq_error set, loads stays 0.
- Stores never affect `loads`.
- mq_idle = (count == 0) && (loads == 0).
- Ordering: strict FIFO; a store behind a load-blocked head also waits (no reordering).

Decomposition:
- Entry struct (writeenable, address, writedata, sizelg2, readtag, readsignextend) and the SIZE_B/H/W/D encodings go in yarvi.h alongside `VMSB/`XMSB.
- One natural sub-module: yarvi_fifo, a generic parameterised-width synchronous FIFO (storage, pointers, count).
- yarvi_mq wraps yarvi_fifo with the load-credit logic and error flag.

Test Plan:
- Reset mid-traffic:
  - Stimulus: fill 3 entries, assert reset_n=0 asynchronously mid-cycle.
  - Response: mq_valid=0, mq_idle=1 and mq_error=0 immediately; the queue is empty after release.
- Basic store:
  - Stimulus: enqueue store addr=0x1000, data=0xDEADBEEF, size=2, me_ready=1.
  - Response: mq_valid=1 next cycle with exact fields; mq_idle returns to 1 the cycle after.
- Full and overflow:
  - Stimulus: me_ready=0, enqueue 4 entries.
  - Response: mq_full=1. A 5th enqueue with enq+deq the same cycle is refused and mq_error=1.
  - Response: entries 1-4 still drain in order when me_ready=1.
- Load credit limit:
  - Stimulus: MAX_LOADS=3, enqueue 4 loads (tags 1..4), me_ready=1, no readdatavalid.
  - Response: tags 1-3 issue, mq_valid=0 with tag 4 at head.
  - Stimulus: one readdatavalid.
  - Response: tag 4 issues the next cycle.
- Simultaneous load dequeue and return:
  - Stimulus: loads=2; dequeue a load while me_readdatavalid=1.
  - Response: loads stays 2, mq_idle=0.
- Underflow:
  - Stimulus: me_readdatavalid=1 with loads=0.
  - Response: mq_error=1, loads=0, mq_idle=1.
- Wrap-around:
  - Stimulus: stream 20 mixed requests with random me_ready.
  - Response: output order and fields match a scoreboard across pointer wrap.

Source files
------------

// File: rtl/yarvi_mq_pkg.sv
`default_nettype none
// ============================================================================
// yarvi_mq_pkg : shared widths, size encodings and queue entry layout
// Revision     : 1.0
// ============================================================================
package yarvi_mq_pkg;

   localparam int VMSB = 31;
   localparam int XMSB = 31;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   typedef struct packed {
      logic          writeenable;
      logic [VMSB:0] address;
      logic [XMSB:0] writedata;
      logic [1:0]    sizelg2;
      logic [4:0]    readtag;
      logic          readsignextend;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage
`default_nettype wire

// File: rtl/yarvi_mq_fifo.sv
`default_nettype none
// ============================================================================
// yarvi_mq_fifo : generic synchronous circular-buffer FIFO, no bypass
// Revision      : 1.0
// ============================================================================
module yarvi_mq_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LG2 = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     wdata,
   output logic [WIDTH-1:0]     rdata,
   output logic [DEPTH_LG2:0]   count,
   output logic                 full
);

   localparam int DEPTH = 1 << DEPTH_LG2;
   localparam logic [DEPTH_LG2:0] FULL_COUNT = (DEPTH_LG2+1)'(DEPTH);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [WIDTH-1:0]     mem_d [DEPTH];
   logic [DEPTH_LG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LG2:0]   count_q, count_d;
   logic                 push_ok, pop_ok;

   assign full  = (count_q == FULL_COUNT);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Guarded locally so a misbehaving caller cannot corrupt the count.
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + (DEPTH_LG2)'(1);
      end
      if (pop_ok)
         rd_ptr_d = rd_ptr_q + (DEPTH_LG2)'(1);
      count_d = count_q + (DEPTH_LG2+1)'(push_ok) - (DEPTH_LG2+1)'(pop_ok);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/yarvi_mq.sv
`default_nettype none
// ============================================================================
// yarvi_mq : ex->me memory request queue with load credit tracking
// Revision : 1.0
// ============================================================================
module yarvi_mq
   import yarvi_mq_pkg::*;
#(
   parameter int DEPTH_LG2 = 2,
   parameter int MAX_LOADS = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          valid,
   input  logic          writeenable,
   input  logic [VMSB:0] address,
   input  logic [XMSB:0] writedata,
   input  logic [1:0]    sizelg2,
   input  logic [4:0]    readtag,
   input  logic          readsignextend,
   output logic          mq_full,
   output logic          mq_idle,
   output logic          mq_valid,
   output logic          mq_writeenable,
   output logic [VMSB:0] mq_address,
   output logic [XMSB:0] mq_writedata,
   output logic [1:0]    mq_sizelg2,
   output logic [4:0]    mq_readtag,
   output logic          mq_readsignextend,
   input  logic          me_ready,
   input  logic          me_readdatavalid,
   output logic          mq_error
);

   localparam logic [3:0] MAX_L = 4'(MAX_LOADS);

   entry_t               enq_entry;
   entry_t               head;
   logic [ENTRY_W-1:0]   head_bits;
   logic [DEPTH_LG2:0]   count;
   logic                 push, pop, head_blocked, deq_load;
   logic [3:0]           loads_q, loads_d;
   logic                 error_q, error_d;

   always_comb begin
      enq_entry.writeenable    = writeenable;
      enq_entry.address        = address;
      enq_entry.writedata      = writedata;
      enq_entry.sizelg2        = sizelg2;
      enq_entry.readtag        = readtag;
      enq_entry.readsignextend = readsignextend;
   end

   yarvi_mq_fifo #(
      .WIDTH     (ENTRY_W),
      .DEPTH_LG2 (DEPTH_LG2)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   (enq_entry),
      .rdata   (head_bits),
      .count   (count),
      .full    (mq_full)
   );

   assign head = head_bits;

   // A load at the head with no credit stalls everything behind it.
   assign head_blocked = !head.writeenable && (loads_q == MAX_L);
   assign mq_valid     = (count != '0) && !head_blocked;
   assign push         = valid && !mq_full;
   assign pop          = mq_valid && me_ready;
   assign deq_load     = pop && !head.writeenable;
   assign mq_idle      = (count == '0) && (loads_q == 4'd0);
   assign mq_error     = error_q;

   assign mq_writeenable    = head.writeenable;
   assign mq_address        = head.address;
   assign mq_writedata      = head.writedata;
   assign mq_sizelg2        = head.sizelg2;
   assign mq_readtag        = head.readtag;
   assign mq_readsignextend = head.readsignextend;

   always_comb begin
      loads_d = loads_q;
      error_d = error_q || (valid && mq_full);
      if (deq_load && !me_readdatavalid)
         loads_d = loads_q + 4'd1;
      else if (!deq_load && me_readdatavalid) begin
         if (loads_q == 4'd0)
            error_d = 1'b1;
         else
            loads_d = loads_q - 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         loads_q <= 4'd0;
         error_q <= 1'b0;
      end else begin
         loads_q <= loads_d;
         error_q <= error_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_yarvi_mq.sv
`default_nettype none
// ============================================================================
// tb_yarvi_mq : directed and streaming checks of yarvi_mq against a queue model
// Revision    : 1.0
// ============================================================================
module tb_yarvi_mq;
   import yarvi_mq_pkg::*;

   localparam int DEPTH_LG2 = 2;
   localparam int DEPTH     = 1 << DEPTH_LG2;
   localparam int MAX_LOADS = 3;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          valid = 1'b0, writeenable = 1'b0;
   logic [VMSB:0] address = '0;
   logic [XMSB:0] writedata = '0;
   logic [1:0]    sizelg2 = '0;
   logic [4:0]    readtag = '0;
   logic          readsignextend = 1'b0;
   logic          me_ready = 1'b0, me_readdatavalid = 1'b0;
   logic          mq_full, mq_idle, mq_valid, mq_writeenable, mq_readsignextend, mq_error;
   logic [VMSB:0] mq_address;
   logic [XMSB:0] mq_writedata;
   logic [1:0]    mq_sizelg2;
   logic [4:0]    mq_readtag;

   int vectors = 0;
   int miscompares = 0;

   entry_t m_q[$];
   int     m_loads = 0;
   bit     m_err = 1'b0;

   always #5 clock = ~clock;

   yarvi_mq #(.DEPTH_LG2(DEPTH_LG2), .MAX_LOADS(MAX_LOADS)) dut (
      .clock(clock), .reset_n(reset_n), .valid(valid), .writeenable(writeenable),
      .address(address), .writedata(writedata), .sizelg2(sizelg2), .readtag(readtag),
      .readsignextend(readsignextend), .mq_full(mq_full), .mq_idle(mq_idle),
      .mq_valid(mq_valid), .mq_writeenable(mq_writeenable), .mq_address(mq_address),
      .mq_writedata(mq_writedata), .mq_sizelg2(mq_sizelg2), .mq_readtag(mq_readtag),
      .mq_readsignextend(mq_readsignextend), .me_ready(me_ready),
      .me_readdatavalid(me_readdatavalid), .mq_error(mq_error)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_head_ok();
      return (m_q.size() > 0) && !(!m_q[0].writeenable && m_loads == MAX_LOADS);
   endfunction

   task automatic compare_model();
      chk("valid", mq_valid, m_head_ok());
      chk("full", mq_full, m_q.size() == DEPTH);
      chk("idle", mq_idle, (m_q.size() == 0) && (m_loads == 0));
      chk("error", mq_error, m_err);
      if (m_q.size() > 0) begin
         chk("we", mq_writeenable, m_q[0].writeenable);
         chk("addr", mq_address, m_q[0].address);
         chk("wdata", mq_writedata, m_q[0].writedata);
         chk("size", mq_sizelg2, m_q[0].sizelg2);
         chk("tag", mq_readtag, m_q[0].readtag);
         chk("sext", mq_readsignextend, m_q[0].readsignextend);
      end
   endtask

   // One clock: decide the model's transition from pre-edge state and inputs.
   task automatic step();
      bit     full_m, deq, deq_load, enq;
      entry_t e;
      full_m   = (m_q.size() == DEPTH);
      deq      = m_head_ok() && me_ready;
      deq_load = deq && !m_q[0].writeenable;
      enq      = valid && !full_m;
      e        = '{writeenable, address, writedata, sizelg2, readtag, readsignextend};
      @(posedge clock);
      #1;
      if (valid && full_m) m_err = 1'b1;
      if (deq_load && !me_readdatavalid) m_loads++;
      else if (!deq_load && me_readdatavalid) begin
         if (m_loads == 0) m_err = 1'b1;
         else m_loads--;
      end
      if (deq) void'(m_q.pop_front());
      if (enq) m_q.push_back(e);
      compare_model();
   endtask

   task automatic req(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic [4:0] tag, input bit se);
      valid = v; writeenable = we; address = a; writedata = d;
      sizelg2 = sz; readtag = tag; readsignextend = se;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_loads = 0;
      m_err   = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int sent, cyc;
      bit v;
      // Power-on reset values
      #1;
      chk("rst_valid", mq_valid, 1'b0);
      chk("rst_full", mq_full, 1'b0);
      chk("rst_idle", mq_idle, 1'b1);
      chk("rst_error", mq_error, 1'b0);
      chk("rst_addr", mq_address, 32'h0);
      chk("rst_wdata", mq_writedata, 32'h0);
      release_reset();

      // Basic store
      me_ready = 1'b1;
      req(1, 1, 32'h1000, 32'hDEADBEEF, SIZE_W, 5'd0, 0);
      step();
      req(0, 0, 0, 0, 0, 0, 0);
      chk("store_valid", mq_valid, 1'b1);
      chk("store_addr", mq_address, 32'h1000);
      chk("store_data", mq_writedata, 32'hDEADBEEF);
      chk("store_size", mq_sizelg2, 2'd2);
      chk("store_we", mq_writeenable, 1'b1);
      step();
      chk("store_idle", mq_idle, 1'b1);

      // Full and overflow with simultaneous dequeue
      me_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req(1, 1, 32'h2000 + 32'(i * 4), 32'hA0 + 32'(i), SIZE_W, 5'd0, 0);
         step();
      end
      chk("full_set", mq_full, 1'b1);
      req(1, 1, 32'h3000, 32'hBAD, SIZE_W, 5'd0, 0);
      me_ready = 1'b1;
      step();
      req(0, 0, 0, 0, 0, 0, 0);
      chk("ovf_error", mq_error, 1'b1);
      chk("ovf_head", mq_writedata, 32'hA1);
      for (int i = 0; i < 3; i++) step();
      chk("ovf_drained", mq_idle, 1'b1);

      // Reset mid-traffic, asserted between clock edges
      me_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req(1, 1, 32'h4000 + 32'(i), 32'h55, SIZE_B, 5'd0, 0);
         step();
      end
      req(0, 0, 0, 0, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_valid", mq_valid, 1'b0);
      chk("async_idle", mq_idle, 1'b1);
      chk("async_error", mq_error, 1'b0);
      model_reset();
      release_reset();
      step();

      // Load credit limit
      for (int i = 1; i <= 4; i++) begin
         req(1, 0, 32'h5000 + 32'(i), 32'h0, SIZE_W, 5'(i), 1);
         step();
      end
      req(0, 0, 0, 0, 0, 0, 0);
      me_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("credit_block", mq_valid, 1'b0);
      chk("credit_tag", mq_readtag, 5'd4);
      step();
      me_readdatavalid = 1'b1;
      step();
      me_readdatavalid = 1'b0;
      chk("credit_release", mq_valid, 1'b1);
      chk("credit_tag4", mq_readtag, 5'd4);
      step();

      // Simultaneous load dequeue and return at loads=2
      me_readdatavalid = 1'b1;
      me_ready = 1'b0;
      req(1, 0, 32'h6000, 32'h0, SIZE_H, 5'd7, 0);
      step();
      req(0, 0, 0, 0, 0, 0, 0);
      me_ready = 1'b1;
      step();
      chk("simul_idle", mq_idle, 1'b0);
      chk("simul_empty", mq_valid, 1'b0);
      step();
      step();
      me_readdatavalid = 1'b0;
      chk("simul_drained", mq_idle, 1'b1);

      // Underflow
      me_readdatavalid = 1'b1;
      step();
      me_readdatavalid = 1'b0;
      chk("unf_error", mq_error, 1'b1);
      chk("unf_idle", mq_idle, 1'b1);
      step();

      // Streaming across pointer wrap
      reset_n = 1'b0;
      #1;
      model_reset();
      release_reset();
      sent = 0;
      cyc  = 0;
      while (sent < 20 && cyc < 400) begin
         v = (m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
         req(v, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         me_ready = 1'($urandom_range(0, 1));
         me_readdatavalid = (m_loads > 0) && ($urandom_range(0, 1) == 1);
         if (v) sent++;
         step();
         cyc++;
      end
      chk("wrap_sent", 32'(sent), 32'd20);
      req(0, 0, 0, 0, 0, 0, 0);
      me_ready = 1'b1;
      cyc = 0;
      while (!(m_q.size() == 0 && m_loads == 0) && cyc < 100) begin
         me_readdatavalid = (m_loads > 0);
         step();
         cyc++;
      end
      me_readdatavalid = 1'b0;
      chk("wrap_idle", mq_idle, 1'b1);
      chk("wrap_error", mq_error, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
